// File: rtl/direct_cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate cache controller sitting
// between a single-requester CPU port and a word-addressed backing memory.
module direct_cache_ctrl #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS      = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_w_data,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_req,
  output logic [31:0] cpu_r_data,
  output logic        cpu_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_r_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int DATA_W = 32;
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  state_t                  state;
  logic [NUM_LINES-1:0]    valid;
  logic [TAG_W-1:0]        tag_arr  [NUM_LINES];
  logic [DATA_W-1:0]       data_arr [NUM_LINES*WORDS_PER_LINE];
  logic [ADDR_W-1:0]       req_addr;
  logic [OFF_W-1:0]        cnt;
  logic [OFF_W-1:0]        cnt_nxt;

  logic [OFF_W-1:0]        c_off, r_off;
  logic [IDX_W-1:0]        c_idx, r_idx;
  logic [TAG_W-1:0]        c_tag, r_tag;
  logic                    hit;
  logic                    unused_addr_bits;

  assign {c_tag, c_idx, c_off} = cpu_addr[ADDR_W-1:0];
  assign {r_tag, r_idx, r_off} = req_addr;
  assign hit      = valid[c_idx] && (tag_arr[c_idx] == c_tag);
  assign cnt_nxt  = cnt + 1'b1;
  assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Tag and data storage: not reset, only qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_wr_req && hit)
      data_arr[{c_idx, c_off}] <= cpu_w_data;
    if (state == REFILL) begin
      data_arr[{r_idx, cnt}] <= mem_r_data;
      if (cnt == LAST_WORD)
        tag_arr[r_idx] <= r_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      req_addr   <= '0;
      cnt        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      cpu_r_data <= '0;
      cpu_ready  <= 1'b0;
      mem_addr   <= '0;
      mem_w_data <= '0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_wr_req) begin
            // A simultaneous read request is dropped in favour of the write.
            req_addr   <= cpu_addr[ADDR_W-1:0];
            mem_wr_en  <= 1'b1;
            mem_addr   <= 32'(cpu_addr[ADDR_W-1:0]);
            mem_w_data <= cpu_w_data;
            state      <= WRITE;
          end else if (cpu_rd_req) begin
            req_addr <= cpu_addr[ADDR_W-1:0];
            if (hit) begin
              cpu_r_data <= data_arr[{c_idx, c_off}];
              hit_count  <= sat_inc(hit_count);
              cpu_ready  <= 1'b1;
              state      <= RESP;
            end else begin
              miss_count <= sat_inc(miss_count);
              cnt        <= '0;
              mem_rd_en  <= 1'b1;
              mem_addr   <= 32'({c_tag, c_idx, {OFF_W{1'b0}}});
              state      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (cnt == LAST_WORD) begin
            valid[r_idx] <= 1'b1;
            // The last word is only now arriving, so bypass it from memory.
            cpu_r_data   <= (r_off == cnt) ? mem_r_data : data_arr[{r_idx, r_off}];
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            cpu_ready    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= 32'({r_tag, r_idx, cnt_nxt});
          end
        end
        WRITE: begin
          mem_wr_en  <= 1'b0;
          mem_addr   <= '0;
          mem_w_data <= '0;
          cpu_ready  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          cpu_ready <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_direct_cache_ctrl.sv
// Directed bench for direct_cache_ctrl with a falling-edge backing memory model.
module tb_direct_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_w_data;
  logic        cpu_rd_req, cpu_wr_req;
  logic [31:0] cpu_r_data;
  logic        cpu_ready;
  logic [31:0] mem_addr, mem_w_data;
  logic        mem_wr_en, mem_rd_en;
  wire  [31:0] mem_r_data;
  logic [15:0] hit_count, miss_count;

  logic [31:0] mem [128];
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat;
  int          rdy_seen;

  direct_cache_ctrl #(.NUM_LINES(8), .WORDS_PER_LINE(4), .MEM_WORDS(128)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_w_data(cpu_w_data),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_r_data(cpu_r_data),
    .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_r_data(mem_r_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign mem_r_data = mem_rd_en ? mem[mem_addr[6:0]] : 32'hz;

  always @(negedge clk) begin
    if (mem_wr_en) mem[mem_addr[6:0]] <= mem_w_data;
    if (mem_rd_en) rd_q.push_back(mem_addr);
    if (mem_wr_en) wr_q.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with requests dropped.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int latency);
    rd_q.delete();
    wr_q.delete();
    cpu_addr = addr; cpu_w_data = wdata; cpu_rd_req = rd; cpu_wr_req = wr;
    @(posedge clk);
    latency = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        latency = i;
        break;
      end
    end
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic chk_refill(input string tag, input logic [31:0] base);
    chk({tag, "_nrd"}, 32'(rd_q.size()), 32'd4);
    if (rd_q.size() == 4)
      for (int i = 0; i < 4; i++) chk({tag, "_addr"}, rd_q[i], base + 32'(i));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy"},  32'(cpu_ready), 32'd0);
    chk({tag, "_rdat"}, cpu_r_data, 32'd0);
    chk({tag, "_men"},  {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwdat"}, mem_w_data, 32'd0);
    chk({tag, "_cnt"},  {hit_count, miss_count}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = (i < 32) ? 32'd0 : 32'hA000_0000 + 32'(i);
    reset = 1'b1; cpu_addr = '0; cpu_w_data = '0; cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    do_req(1'b0, 1'b1, 32'd5, 32'h1234_5678, lat);
    chk("wr5_lat", 32'(lat), 32'd2);
    chk("wr5_nwr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) chk("wr5_addr", wr_q[0], 32'd5);
    chk("wr5_nrd", 32'(rd_q.size()), 32'd0);
    chk("wr5_mem", mem[5], 32'h1234_5678);
    chk("wr5_cnt", {hit_count, miss_count}, 32'h0000_0000);

    do_req(1'b1, 1'b0, 32'd5, 32'd0, lat);
    chk("rd5_lat", 32'(lat), 32'd5);
    chk_refill("rd5", 32'd4);
    chk("rd5_data", cpu_r_data, 32'h1234_5678);
    chk("rd5_cnt", {hit_count, miss_count}, 32'h0000_0001);

    do_req(1'b1, 1'b0, 32'd6, 32'd0, lat);
    chk("rd6_lat", 32'(lat), 32'd1);
    chk("rd6_nrd", 32'(rd_q.size()), 32'd0);
    chk("rd6_data", cpu_r_data, 32'd0);
    chk("rd6_cnt", {hit_count, miss_count}, 32'h0001_0001);

    do_req(1'b0, 1'b1, 32'd6, 32'hCAFE_F00D, lat);
    chk("wr6_lat", 32'(lat), 32'd2);
    chk("wr6_mem", mem[6], 32'hCAFE_F00D);
    chk("wr6_hold", cpu_r_data, 32'd0);
    chk("wr6_cnt", {hit_count, miss_count}, 32'h0001_0001);

    do_req(1'b1, 1'b0, 32'd6, 32'd0, lat);
    chk("rd6b_lat", 32'(lat), 32'd1);
    chk("rd6b_data", cpu_r_data, 32'hCAFE_F00D);
    chk("rd6b_cnt", {hit_count, miss_count}, 32'h0002_0001);

    do_req(1'b1, 1'b0, 32'd37, 32'd0, lat);
    chk("rd37_lat", 32'(lat), 32'd5);
    chk_refill("rd37", 32'd36);
    chk("rd37_data", cpu_r_data, 32'hA000_0025);
    do_req(1'b1, 1'b0, 32'd5, 32'd0, lat);
    chk("rd5b_lat", 32'(lat), 32'd5);
    chk_refill("rd5b", 32'd4);
    chk("rd5b_data", cpu_r_data, 32'h1234_5678);
    chk("conflict_cnt", {hit_count, miss_count}, 32'h0002_0003);

    // Line 1 now holds tag 0; re-fetch tag 1, then write to tag 0 (miss, no allocate).
    do_req(1'b1, 1'b0, 32'd37, 32'd0, lat);
    chk("rd37b_lat", 32'(lat), 32'd5);
    do_req(1'b1, 1'b1, 32'd7, 32'h1111_2222, lat);
    chk("rdwr7_lat", 32'(lat), 32'd2);
    chk("rdwr7_nrd", 32'(rd_q.size()), 32'd0);
    chk("rdwr7_nwr", 32'(wr_q.size()), 32'd1);
    chk("rdwr7_mem", mem[7], 32'h1111_2222);
    chk("rdwr7_cnt", {hit_count, miss_count}, 32'h0002_0004);
    chk("rdwr7_hold", cpu_r_data, 32'hA000_0025);
    do_req(1'b1, 1'b0, 32'd7, 32'd0, lat);
    chk("rd7_lat", 32'(lat), 32'd5);
    chk_refill("rd7", 32'd4);
    chk("rd7_data", cpu_r_data, 32'h1111_2222);

    // Evict line 1 again, then reset part-way through the refill of addr 5.
    do_req(1'b1, 1'b0, 32'd37, 32'd0, lat);
    cpu_addr = 32'd5; cpu_rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_idle_outputs("async_reset");
    cpu_rd_req = 1'b0;
    rdy_seen = 0;
    repeat (2) @(negedge clk) if (cpu_ready) rdy_seen++;
    reset = 1'b0;
    repeat (3) @(negedge clk) if (cpu_ready) rdy_seen++;
    chk("abandon_ready", 32'(rdy_seen), 32'd0);
    do_req(1'b1, 1'b0, 32'd5, 32'd0, lat);
    chk("rd5c_lat", 32'(lat), 32'd5);
    chk_refill("rd5c", 32'd4);
    chk("rd5c_data", cpu_r_data, 32'h1234_5678);
    chk("rd5c_cnt", {hit_count, miss_count}, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/direct_cache_ctrl.md
DIRECT_CACHE_CTRL -- requirements
Module: direct_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (fixed; index = cpu_addr[4:2]).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (fixed; offset = cpu_addr[1:0]).
REQ-003 SHALL have parameter MEM_WORDS, default 128, backing-memory depth in words (tag = cpu_addr[6:5]).
REQ-004 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cpu_addr  input  32  word address; bits [31:7] ignored.
REQ-007 SHALL have port cpu_w_data  input  32  CPU write data.
REQ-008 SHALL have port cpu_rd_req  input  1  read request, held stable until cpu_ready.
REQ-009 SHALL have port cpu_wr_req  input  1  write request, held stable until cpu_ready.
REQ-010 SHALL have port cpu_r_data  output  32  registered read data.
REQ-011 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_addr  output  32  word address to backing memory; bits [31:7] always 0.
REQ-013 SHALL have port mem_w_data  output  32  write data to backing memory.
REQ-014 SHALL have port mem_wr_en  output  1  memory write enable (memory commits on falling clk edge).
REQ-015 SHALL have port mem_rd_en  output  1  memory read enable (memory drives data combinationally, else Z).
REQ-016 SHALL have port mem_r_data  input  32  memory read data, valid before next rising edge.
REQ-017 SHALL have ports hit_count, miss_count  output  16 each  read-hit / read-miss counters.

Function
REQ-018 SHALL hold per line: valid bit, 2-bit tag, 4x32-bit data; hit = valid AND tag match at index.
REQ-019 SHALL implement FSM states IDLE, REFILL, WRITE, RESP; requests sampled only in IDLE.
REQ-020 SHALL treat cpu_rd_req and cpu_wr_req both high as a write; read request ignored.
REQ-021 Read hit SHALL: at sampling edge load cpu_r_data with cached word, go to RESP; hit_count+1.
REQ-022 Read miss SHALL: go to REFILL with counter 0, miss_count+1; no cache state changes at that edge.
REQ-023 REFILL SHALL last exactly 4 cycles: mem_rd_en=1, mem_addr={tag,index,cnt}, cnt 0..3; each edge stores mem_r_data into word cnt.
REQ-024 On the 4th REFILL edge SHALL set valid, write tag, load cpu_r_data with requested word, go to RESP.
REQ-025 Write SHALL be write-through, no-write-allocate: at sampling edge update cached word only if hit, go to WRITE.
REQ-026 WRITE SHALL last 1 cycle: mem_wr_en=1, mem_addr=cpu_addr[6:0], mem_w_data=cpu_w_data; then RESP.
REQ-027 RESP SHALL assert cpu_ready for exactly 1 cycle, ignore requests, return to IDLE.
REQ-028 Latency from sampling edge to cpu_ready high SHALL be: read hit 1 cycle, read miss 5 cycles, write 2 cycles.
REQ-029 mem_rd_en and mem_wr_en SHALL be mutually exclusive and 0 outside REFILL/WRITE; mem_addr, mem_w_data 0 when idle.
REQ-030 Writes SHALL not change hit_count or miss_count.
REQ-031 Counters SHALL saturate at 16'hFFFF.
REQ-032 cpu_r_data SHALL hold its value until the next read completes.
REQ-033 Miss to an occupied index SHALL overwrite the line (no write-back; memory already current).

Reset
REQ-034 reset SHALL asynchronously clear all valid bits, force IDLE, counters 0, cpu_r_data 0, cpu_ready 0, all mem_* outputs 0.
REQ-035 Reset during REFILL or WRITE SHALL abandon the request without cpu_ready; partly filled line stays invalid.
REQ-036 Tag/data arrays need not be cleared by reset.

Verification
REQ-037 Write 0x12345678 to addr 5 after reset -> one cycle mem_wr_en=1, mem_addr=5; cpu_ready 2 cycles after sample; counters 0/0.
REQ-038 Then read addr 5 -> mem_rd_en 4 cycles at addrs 4,5,6,7; cpu_ready 5 cycles after sample, cpu_r_data=0x12345678, miss_count=1.
REQ-039 Then read addr 6 -> no mem_rd_en; cpu_ready 1 cycle after sample, cpu_r_data=0, hit_count=1.
REQ-040 Write 0xCAFEF00D to addr 6 (hit), then read addr 6 -> memory word 6 = 0xCAFEF00D, read hits, cpu_r_data=0xCAFEF00D.
REQ-041 Read addr 37 (index 1, tag 1), then read addr 5 -> both miss (refill addrs 36..39, then 4..7); miss_count +2.
REQ-042 Assert reset in 3rd REFILL cycle of read addr 5 -> outputs 0 immediately, no cpu_ready; later read addr 5 misses with full 4-word refill.
